// File: rtl/mci_block_controller.sv
// mci_block_controller
//   Responder end of the memory-controller interface. Takes one block request
//   from a cache, moves it over a narrow word-wide backing-memory bus one beat
//   at a time (req/ack handshake), reassembles read blocks and answers with a
//   one-cycle ready pulse.
//
//   Optional feature macro: MCI_CTRL_STATS_EN
//     When defined, the rd_count/wr_count ports and their counters are present.
//
// Ports
//   clk        in   1                  clock
//   rst        in   1                  asynchronous reset, active-high
//   mem_req    in   ADDR+DATA+2        packed request {addr, data, rw, valid}
//   mem_res    out  DATA+1             packed response {ready, data}
//   bus_req    out  1                  beat request to backing memory
//   bus_we     out  1                  1 = write beat, 0 = read beat
//   bus_addr   out  ADDR_LENGTH        byte address of the current beat
//   bus_wdata  out  BUS_WIDTH          write beat data
//   bus_rdata  in   BUS_WIDTH          read beat data, valid with bus_ack
//   rd_count   out  32                 completed block reads  (stats build)
//   wr_count   out  32                 completed block writes (stats build)
//   bus_ack    in   1                  beat complete pulse
module mci_block_controller #(
    parameter int MCI_DATA_LENGTH = 128,
    parameter int ADDR_LENGTH     = 32,
    parameter int BUS_WIDTH       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_LENGTH+MCI_DATA_LENGTH+1:0] mem_req,
    output logic [MCI_DATA_LENGTH:0]               mem_res,
    output logic                                   bus_req,
    output logic                                   bus_we,
    output logic [ADDR_LENGTH-1:0]                 bus_addr,
    output logic [BUS_WIDTH-1:0]                   bus_wdata,
    input  logic [BUS_WIDTH-1:0]                   bus_rdata,
`ifdef MCI_CTRL_STATS_EN
    output logic [31:0]                            rd_count,
    output logic [31:0]                            wr_count,
`endif
    input  logic                                   bus_ack
);

    localparam int BEATS = MCI_DATA_LENGTH / BUS_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [IDX_W-1:0]       LAST_IDX    = IDX_W'(BEATS - 1);
    localparam logic [ADDR_LENGTH-1:0] BEAT_STRIDE = ADDR_LENGTH'(BUS_WIDTH / 8);
    // Clears the byte-within-block offset to form the block base address.
    localparam logic [ADDR_LENGTH-1:0] BLOCK_MASK  = ~ADDR_LENGTH'((MCI_DATA_LENGTH / 8) - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [ADDR_LENGTH-1:0]     req_addr;
    logic [MCI_DATA_LENGTH-1:0] req_data;
    logic                       req_rw;
    logic                       req_valid;
    logic [ADDR_LENGTH-1:0]     req_base;

    logic [1:0]                 state;
    logic [IDX_W-1:0]           beat_idx;
    logic [IDX_W-1:0]           next_idx;
    logic                       last_beat;
    logic [MCI_DATA_LENGTH-1:0] wblk;
    logic [MCI_DATA_LENGTH-1:0] rbuf;
    logic [MCI_DATA_LENGTH-1:0] rd_assembled;
    logic                       res_ready;
    logic [MCI_DATA_LENGTH-1:0] res_data;

    assign {req_addr, req_data, req_rw, req_valid} = mem_req;
    assign req_base  = req_addr & BLOCK_MASK;
    assign mem_res   = {res_ready, res_data};
    assign next_idx  = beat_idx + 1'b1;
    assign last_beat = (beat_idx == LAST_IDX);

    // Read buffer with the word arriving this cycle merged in, so the final
    // beat can be forwarded straight into the response register.
    always_comb begin
        rd_assembled = rbuf;
        rd_assembled[beat_idx*BUS_WIDTH +: BUS_WIDTH] = bus_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_idx  <= '0;
            wblk      <= '0;
            rbuf      <= '0;
            res_ready <= 1'b0;
            res_data  <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            res_ready <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    // RESP accepts a new request too, giving back-to-back
                    // transfers with no idle cycle in between.
                    if (req_valid) begin
                        state     <= BEAT;
                        beat_idx  <= '0;
                        wblk      <= req_data;
                        bus_req   <= 1'b1;
                        bus_we    <= req_rw;
                        bus_addr  <= req_base;
                        bus_wdata <= req_data[BUS_WIDTH-1:0];
                    end else begin
                        state <= IDLE;
                    end
                end
                BEAT: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rbuf <= rd_assembled;
                        end
                        if (last_beat) begin
                            state     <= RESP;
                            bus_req   <= 1'b0;
                            res_ready <= 1'b1;
                            if (!bus_we) begin
                                res_data <= rd_assembled;
                            end
                        end else begin
                            beat_idx  <= next_idx;
                            bus_addr  <= bus_addr + BEAT_STRIDE;
                            bus_wdata <= wblk[next_idx*BUS_WIDTH +: BUS_WIDTH];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MCI_CTRL_STATS_EN
    // Counts land on the same edge that raises ready, so they are current
    // during the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == BEAT && bus_ack && last_beat) begin
            if (bus_we) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mci_block_controller.sv
module tb_mci_block_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic [161:0] mem_req;
    logic [128:0] mem_res;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ack;
`ifdef MCI_CTRL_STATS_EN
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
`endif

    mci_block_controller dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_res   (mem_res),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
`ifdef MCI_CTRL_STATS_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Backing memory model: word array, programmable ack wait per beat.
    logic [31:0] mem [0:4095];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    int          unstable = 0;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [31:0] log_addr [$];
    logic        log_we [$];
    logic [31:0] log_wdata [$];

    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (bus_req && !rst) begin
            if (wait_cnt == 0) begin
                hold_addr  = bus_addr;
                hold_wdata = bus_wdata;
            end else if (bus_addr !== hold_addr || bus_wdata !== hold_wdata) begin
                unstable++;
            end
            if (wait_cnt >= ack_wait) begin
                bus_ack   = 1'b1;
                bus_rdata = mem[bus_addr[13:2]];
                if (bus_we) mem[bus_addr[13:2]] = bus_wdata;
                log_addr.push_back(bus_addr);
                log_we.push_back(bus_we);
                log_wdata.push_back(bus_wdata);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle starting at a negedge, then scrambles
    // the request fields to show the DUT latched them.
    task automatic issue(input logic [31:0] a, input logic [127:0] d, input logic rw);
        mem_req = {a, d, rw, 1'b1};
        @(posedge clk);
        #1;
        mem_req = {32'hDEAD_BEEF, {4{32'hBAD0_BAD0}}, ~rw, 1'b0};
    endtask

    // Counts cycles after the accept edge until ready; -1 on timeout.
    task automatic wait_ready(output int lat, output logic [127:0] data);
        lat  = -1;
        data = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (mem_res[128]) begin
                lat  = i;
                data = mem_res[127:0];
                return;
            end
        end
    endtask

    function automatic void clear_log();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
    endfunction

    localparam logic [127:0] RD_BLK = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] WR_BLK = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    localparam logic [127:0] W3_BLK = 128'h3333_0003_3333_0002_3333_0001_3333_0000;
    localparam logic [127:0] W4_BLK = 128'h4444_0003_4444_0002_4444_0001_4444_0000;

    int           lat;
    logic [127:0] data;
    logic         found;
    logic         seen_ready;

    initial begin
        rst       = 1'b1;
        mem_req   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h48C] = 32'h11;
        mem[12'h48D] = 32'h22;
        mem[12'h48E] = 32'h33;
        mem[12'h48F] = 32'h44;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",  128'(mem_res[128]),    128'(0));
        check("rst_data",   mem_res[127:0],        128'(0));
        check("rst_bus_req",128'(bus_req),         128'(0));
        check("rst_bus_we", 128'(bus_we),          128'(0));
        check("rst_addr",   128'(bus_addr),        128'(0));
        check("rst_wdata",  128'(bus_wdata),       128'(0));
        rst = 1'b0;
        @(negedge clk);

        // 1: zero-wait read of 0x1234
        clear_log();
        ack_wait = 0;
        issue(32'h0000_1234, 128'h0, 1'b0);
        wait_ready(lat, data);
        check("t1_latency", 128'(lat), 128'(5));
        check("t1_data", data, RD_BLK);
        check("t1_nbeats", 128'(log_addr.size()), 128'(4));
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check($sformatf("t1_addr%0d", i), 128'(log_addr[i]), 128'(32'h1230 + 4 * i));
            check($sformatf("t1_we%0d", i), 128'(log_we[i]), 128'(0));
        end
        @(negedge clk);
        check("t1_ready_drop", 128'(mem_res[128]), 128'(0));
        check("t1_data_held", mem_res[127:0], RD_BLK);

        // 2: zero-wait write to 0x2000
        clear_log();
        issue(32'h0000_2000, WR_BLK, 1'b1);
        wait_ready(lat, data);
        check("t2_latency", 128'(lat), 128'(5));
        check("t2_data_unchanged", data, RD_BLK);
        check("t2_nbeats", 128'(log_addr.size()), 128'(4));
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check($sformatf("t2_addr%0d", i), 128'(log_addr[i]), 128'(32'h2000 + 4 * i));
            check($sformatf("t2_wdata%0d", i), 128'(log_wdata[i]), 128'(32'hCAFE_0000 + i));
            check($sformatf("t2_we%0d", i), 128'(log_we[i]), 128'(1));
        end
        @(negedge clk);

        // 3: three wait cycles per beat, write to 0x3100
        clear_log();
        ack_wait = 3;
        unstable = 0;
        issue(32'h0000_3104, W3_BLK, 1'b1);
        wait_ready(lat, data);
        check("t3_latency", 128'(lat), 128'(17));
        check("t3_stable", 128'(unstable), 128'(0));
        check("t3_nbeats", 128'(log_addr.size()), 128'(4));
        if (log_addr.size() == 4) begin
            check("t3_last_addr",  128'(log_addr[3]),  128'(32'h310C));
            check("t3_last_wdata", 128'(log_wdata[3]), 128'(32'h3333_0003));
        end
        seen_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_res[128]) seen_ready = 1'b1;
        end
        check("t3_single_pulse", 128'(seen_ready), 128'(0));

        // 4: write-back to 0x2010 then fill from the same block, back to back
        ack_wait = 0;
        issue(32'h0000_2010, W4_BLK, 1'b1);
        wait_ready(lat, data);
        check("t4_wr_latency", 128'(lat), 128'(5));
        issue(32'h0000_2018, 128'h0, 1'b0);
        check("t4_no_gap_req",  128'(bus_req),  128'(1));
        check("t4_no_gap_we",   128'(bus_we),   128'(0));
        check("t4_no_gap_addr", 128'(bus_addr), 128'(32'h2010));
        wait_ready(lat, data);
        check("t4_rd_latency", 128'(lat), 128'(5));
        check("t4_rd_data", data, W4_BLK);
        @(negedge clk);

        // 5: reset during beat 2 of a read
        ack_wait = 2;
        issue(32'h0000_1234, 128'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus_req && bus_addr == 32'h1238) found = 1'b1;
        end
        check("t5_reach_beat2", 128'(found), 128'(1));
        rst = 1'b1;
        #1;
        check("t5_req_drop", 128'(bus_req), 128'(0));
        seen_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_res[128]) seen_ready = 1'b1;
        end
        check("t5_no_ready", 128'(seen_ready), 128'(0));
        check("t5_data_cleared", mem_res[127:0], 128'(0));
        rst = 1'b0;
        @(negedge clk);
        ack_wait = 0;
        issue(32'h0000_1234, 128'h0, 1'b0);
        wait_ready(lat, data);
        check("t5_latency", 128'(lat), 128'(5));
        check("t5_data", data, RD_BLK);
        @(negedge clk);

`ifdef MCI_CTRL_STATS_EN
        // 6: counters since the reset in step 5
        check("t6_rd_after1", 128'(rd_count), 128'(1));
        check("t6_wr_after1", 128'(wr_count), 128'(0));
        issue(32'h0000_3200, W3_BLK, 1'b1);
        wait_ready(lat, data);
        @(negedge clk);
        issue(32'h0000_1230, 128'h0, 1'b0);
        wait_ready(lat, data);
        @(negedge clk);
        issue(32'h0000_3210, W4_BLK, 1'b1);
        wait_ready(lat, data);
        @(negedge clk);
        issue(32'h0000_3200, 128'h0, 1'b0);
        wait_ready(lat, data);
        check("t6_rd_data", data, W3_BLK);
        @(negedge clk);
        check("t6_rd_count", 128'(rd_count), 128'(3));
        check("t6_wr_count", 128'(wr_count), 128'(2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
